unsat_clause_selector: RTL and testbench

- Picks a uniformly distributed index into the unsat-clause buffer by computing selected = N mod m without a divider.
- N is an 18-bit field of a 32-bit random word; m is the current unsat-buffer occupancy.
- The modulo uses a reciprocal (1/m) lookup table, a multiply, and a one-step remainder correction.
- Sits between the random-number generator and the unsat clause buffer read port in the WalkSAT datapath.

---
 rtl/unsat_clause_selector_pkg.sv | 20 ++
 rtl/unsat_clause_selector_if.sv | 25 ++
 rtl/recip_table_ram.sv | 37 +++
 rtl/unsat_clause_selector.sv | 81 ++++++++
 tb/tb_unsat_clause_selector.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/unsat_clause_selector_pkg.sv
// Shared sizing constants and the reciprocal-table entry function for the unsat clause selector.
package unsat_clause_selector_pkg;

  localparam int unsigned BufferDepth  = 2048;
  localparam int unsigned AW           = $clog2(BufferDepth);
  localparam int unsigned RandomOffset = 10;
  localparam int unsigned RW           = 18;
  localparam int unsigned MW           = 32;
  localparam int unsigned RandWidth    = 32;

  // Entry k holds floor((2^MW - 1) / k); entry 0 stands for a full buffer.
  function automatic logic [MW-1:0] recip_entry(input int unsigned k);
    logic [MW:0] den;
    logic [MW:0] quo;
    den = (k % BufferDepth == 0) ? (MW+1)'(BufferDepth) : (MW+1)'(k % BufferDepth);
    quo = {1'b0, {MW{1'b1}}} / den;
    return quo[MW-1:0];
  endfunction

endpackage

// File: rtl/unsat_clause_selector_if.sv
// Table-load and datapath signals between the random source, the selector and the buffer.
interface unsat_clause_selector_if;
  import unsat_clause_selector_pkg::*;

  logic                 setup;
  logic                 ready;
  logic [AW-1:0]        write_addr_i;
  logic [MW-1:0]        mt_data_i;
  logic                 mt_en_i;
  logic [AW-1:0]        unsat_buffer_count_i;
  logic [RandWidth-1:0] random_i;
  logic [AW-1:0]        selected_o;
  logic [MW-1:0]        mt_data_o;

  modport master (
    output setup, write_addr_i, mt_data_i, mt_en_i, unsat_buffer_count_i, random_i,
    input  ready, selected_o, mt_data_o
  );

  modport slave (
    input  setup, write_addr_i, mt_data_i, mt_en_i, unsat_buffer_count_i, random_i,
    output ready, selected_o, mt_data_o
  );

endinterface

// File: rtl/recip_table_ram.sv
// Reciprocal table: synchronous RAM, one write port, one registered read port, read-first.
module recip_table_ram #(
  parameter int unsigned Depth = 2048,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage has no reset so the table survives a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unsat_clause_selector.sv
// Selects N mod m for the unsat buffer read port using reciprocal multiply plus one correction.
module unsat_clause_selector
  import unsat_clause_selector_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  unsat_clause_selector_if.slave bus
);

  logic [MW-1:0]    mt_data;
  logic [AW-1:0]    m1_q, m2_q;
  logic [RW-1:0]    n_r1_q, n_r2_q;
  logic [RW+MW-1:0] product2_q, product2_d;
  logic [AW-1:0]    selected_q, selected_d;
  logic             ready_q;
  logic [RW-1:0]    n_in;

  recip_table_ram #(
    .Depth (BufferDepth),
    .Width (MW)
  ) u_recip_table_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (bus.setup),
    .waddr_i (bus.write_addr_i),
    .wdata_i (bus.mt_data_i),
    .re_i    (bus.mt_en_i),
    .raddr_i (bus.unsat_buffer_count_i),
    .rdata_o (mt_data)
  );

  assign n_in = bus.random_i[RandomOffset +: RW];

  logic unused_bits;
  assign unused_bits = ^{bus.random_i[RandWidth-1:RandomOffset+RW],
                         bus.random_i[RandomOffset-1:0], product2_q[MW-1:0]};

  logic [RW-1:0] q, me_ext, r;
  logic [AW:0]   me;

  always_comb begin
    product2_d = {{MW{1'b0}}, n_r1_q} * {{RW{1'b0}}, mt_data};
    q          = product2_q[MW +: RW];
    me         = (m2_q == '0) ? (AW+1)'(BufferDepth) : {1'b0, m2_q};
    me_ext     = {{(RW-AW-1){1'b0}}, me};
    // q underestimates N/m by at most one, so r < 2m and one subtraction suffices.
    r          = n_r2_q - q * me_ext;
    selected_d = (r >= me_ext) ? AW'(r - me_ext) : AW'(r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m1_q       <= '0;
      m2_q       <= '0;
      n_r1_q     <= '0;
      n_r2_q     <= '0;
      product2_q <= '0;
      selected_q <= '0;
    end else if (bus.mt_en_i) begin
      m1_q       <= bus.unsat_buffer_count_i;
      n_r1_q     <= n_in;
      product2_q <= product2_d;
      n_r2_q     <= n_r1_q;
      m2_q       <= m1_q;
      selected_q <= selected_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ~bus.setup;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.selected_o = selected_q;
  assign bus.mt_data_o  = mt_data;

endmodule

// File: tb/tb_unsat_clause_selector.sv
// Bench for unsat_clause_selector: table load/readback, directed vectors, random streams, stalls.
module tb_unsat_clause_selector;
  import unsat_clause_selector_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unsat_clause_selector_if sel_if ();

  unsat_clause_selector u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sel_if.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [MW-1:0] tbl [BufferDepth];

  typedef struct {
    string       name;
    logic [10:0] cnt;
    logic [31:0] rnd;
    int unsigned exp;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer modulo, a zero count meaning a full buffer.
  function automatic int unsigned ref_mod(input logic [10:0] cnt, input logic [31:0] rnd);
    int unsigned n, m;
    n = (rnd >> RandomOffset) & 32'h3FFFF;
    m = (cnt == 0) ? BufferDepth : int'(cnt);
    return n % m;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    sel_if.mt_en_i = 1'b0;
    @(negedge clk);
    check("reset_selected", 32'(sel_if.selected_o), 0);
    check("reset_ready", 32'(sel_if.ready), 0);
    check("reset_mt_data", sel_if.mt_data_o, 0);
    reset = 1'b0;
  endtask

  task automatic readback(input int unsigned cnt);
    @(negedge clk);
    sel_if.mt_en_i = 1'b1;
    sel_if.unsat_buffer_count_i = AW'(cnt);
    @(negedge clk);
    check($sformatf("readback_%0d", cnt), sel_if.mt_data_o, tbl[cnt % BufferDepth]);
  endtask

  // Output after the e-th enabled edge belongs to the input accepted at enabled edge e-2.
  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len);
    int unsigned exp_q[$];
    int   edges_en = 0;
    logic en_prev = 1'b0;
    logic en;
    logic [10:0] c;
    logic [31:0] rv;
    pulse_reset();
    for (int cyc = 0; cyc < n + stall_len + 4; cyc++) begin
      @(negedge clk);
      if (en_prev) edges_en++;
      if (cyc > 0) begin
        check($sformatf("%s_cyc%0d", tag, cyc), 32'(sel_if.selected_o),
              (edges_en >= 3) ? exp_q[edges_en-3] : 0);
      end
      en = !(cyc >= stall_at && cyc < stall_at + stall_len);
      c  = 11'($urandom_range(0, 2047));
      rv = $urandom;
      sel_if.unsat_buffer_count_i = c;
      sel_if.random_i = rv;
      sel_if.mt_en_i = en;
      if (en) exp_q.push_back(ref_mod(c, rv));
      en_prev = en;
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] d;

    vecs[0] = '{"basic_7",        11'd7,    32'h000F_AC00, 2};
    vecs[1] = '{"full_buf",       11'd0,    32'h004E_2000, 904};
    vecs[2] = '{"m1_nmax",        11'd1,    32'h0FFF_FC00, 0};
    vecs[3] = '{"m2047_nmax",     11'd2047, 32'h0FFF_FC00, 127};
    vecs[4] = '{"n0_m5",          11'd5,    32'h0000_0000, 0};
    vecs[5] = '{"n0_full",        11'd0,    32'hF000_03FF, 0};
    vecs[6] = '{"outside_bits",   11'd10,   32'hF000_FFFF, 3};
    vecs[7] = '{"full_nmax",      11'd0,    32'h0FFF_FC00, 2047};

    reset = 1'b1;
    sel_if.setup = 1'b0;
    sel_if.write_addr_i = '0;
    sel_if.mt_data_i = '0;
    sel_if.mt_en_i = 1'b0;
    sel_if.unsat_buffer_count_i = '0;
    sel_if.random_i = '0;
    repeat (2) @(negedge clk);
    check("init_selected", 32'(sel_if.selected_o), 0);
    check("init_ready", 32'(sel_if.ready), 0);
    check("init_mt_data", sel_if.mt_data_o, 0);
    reset = 1'b0;

    // Load 2049 words; address 2048 wraps onto entry 0 and overwrites the junk placed there.
    sel_if.setup = 1'b1;
    for (int i = 0; i <= 2048; i++) begin
      @(negedge clk);
      d = (i == 0) ? 32'hDEAD_BEEF : recip_entry(i);
      sel_if.write_addr_i = AW'(i);
      sel_if.mt_data_i = d;
      tbl[i % BufferDepth] = d;
    end
    @(negedge clk);
    check("ready_in_setup", 32'(sel_if.ready), 0);
    sel_if.setup = 1'b0;
    @(negedge clk);
    check("ready_after_setup", 32'(sel_if.ready), 1);

    sel_if.mt_en_i = 1'b1;
    for (int c = 1; c <= 2049; c++) begin
      @(negedge clk);
      if (c >= 2) check($sformatf("sweep_%0d", c - 1), sel_if.mt_data_o, tbl[(c - 1) % 2048]);
      if (c <= 2048) sel_if.unsat_buffer_count_i = AW'(c);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      sel_if.mt_en_i = 1'b1;
      sel_if.unsat_buffer_count_i = vecs[i].cnt;
      sel_if.random_i = vecs[i].rnd;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(vecs[i].name, 32'(sel_if.selected_o), vecs[i].exp);
    end

    run_stream("stream", 30, 1000, 0);
    run_stream("stall", 12, 6, 3);

    // Reset with a full pipeline discards it and leaves the table intact.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sel_if.mt_en_i = 1'b1;
      sel_if.unsat_buffer_count_i = 11'd3;
      sel_if.random_i = 32'h0FFF_FC00;
    end
    pulse_reset();
    @(negedge clk);
    check("ready_after_reset", 32'(sel_if.ready), 1);
    readback(3);
    readback(0);
    readback(2047);
    readback(1000);

    // Read and write the same entry in one cycle: old data first, new data on the next read.
    @(negedge clk);
    sel_if.setup = 1'b1;
    sel_if.write_addr_i = 11'd5;
    sel_if.mt_data_i = 32'h1234_5678;
    sel_if.mt_en_i = 1'b1;
    sel_if.unsat_buffer_count_i = 11'd5;
    @(negedge clk);
    check("collision_old", sel_if.mt_data_o, recip_entry(5));
    sel_if.setup = 1'b0;
    tbl[5] = 32'h1234_5678;
    @(negedge clk);
    check("collision_new", sel_if.mt_data_o, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
